// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Scan sequencer for an N:1 single-bit channel multiplexer. It steps the mux
//   select through every enabled channel in ascending order and holds each
//   select for SETTLE cycles. It samples the mux output into a working word
//   and delivers the finished N-bit snapshot over a valid/ready handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active high
//   start       scan request, accepted only while idle
//   mask[N]     channel enables, captured on the accepting edge
//   mux_in      sampled output of the external mux
//   sel[SEL_W]  mux select, registered
//   busy        high from start acceptance until the snapshot is taken
//   snap[N]     last completed snapshot (masked channels read 0)
//   snap_valid  snapshot available
//   snap_ready  consumer accepts the snapshot
//   start_drop  one-cycle pulse: a start arrived while busy and was discarded
module mux_scan_ctrl #(
   parameter int N      = 16,
   parameter int SEL_W  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     mask,
   input  logic             mux_in,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic [N-1:0]     snap,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic             start_drop
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     mask_q, mask_d;
   logic [N-1:0]     work_q, work_d;
   logic [N-1:0]     snap_q, snap_d;
   logic             snap_valid_q, snap_valid_d;
   logic             busy_q, busy_d;
   logic             start_drop_q, start_drop_d;

   logic             first_found;
   logic [SEL_W-1:0] first_idx;
   logic             next_found;
   logic [SEL_W-1:0] next_idx;
   logic [N-1:0]     work_merged;

   // Lowest enabled channel of the incoming mask (used on the accepting edge)
   // and the next enabled channel above the current select in the latched mask.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int i = 0; i < N; i++) begin
         if (mask[i] && !first_found) begin
            first_found = 1'b1;
            first_idx   = SEL_W'(i);
         end
         if (mask_q[i] && (i > int'(sel_q)) && !next_found) begin
            next_found = 1'b1;
            next_idx   = SEL_W'(i);
         end
      end
   end

   // Working word with the bit currently being sampled already merged, so the
   // final channel lands in the snapshot on the same edge it is sampled.
   always_comb begin
      work_merged        = work_q;
      work_merged[sel_q] = mux_in;
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      mask_d       = mask_q;
      work_d       = work_q;
      snap_d       = snap_q;
      snap_valid_d = snap_valid_q;
      busy_d       = busy_q;
      start_drop_d = start && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d = mask;
               work_d = '0;
               busy_d = 1'b1;
               if (!first_found) begin
                  // Empty mask: publish an all-zero snapshot at once.
                  snap_d       = '0;
                  snap_valid_d = 1'b1;
                  state_d      = ST_DONE;
               end else begin
                  sel_d   = first_idx;
                  cnt_d   = CNT_RELOAD;
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               work_d = work_merged;
               if (next_found) begin
                  sel_d = next_idx;
                  cnt_d = CNT_RELOAD;
               end else begin
                  snap_d       = work_merged;
                  snap_valid_d = 1'b1;
                  sel_d        = '0;
                  state_d      = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (snap_valid_q && snap_ready) begin
               snap_valid_d = 1'b0;
               busy_d       = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= '0;
         cnt_q        <= '0;
         mask_q       <= '0;
         work_q       <= '0;
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         start_drop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         work_q       <= work_d;
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
         busy_q       <= busy_d;
         start_drop_q <= start_drop_d;
      end
   end

   assign sel        = sel_q;
   assign busy       = busy_q;
   assign snap       = snap_q;
   assign snap_valid = snap_valid_q;
   assign start_drop = start_drop_q;

endmodule
